// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider (div_seq):
//   WIDTH_DEF  - default operand/result width
//   state_t    - controller state encodings (IDLE / RUN / DONE)
//   cnt_width  - iteration-counter width for a given operand width
//   CNT_W      - iteration-counter width at the default operand width
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational iteration of restoring unsigned division.
// Ports:
//   rem_in   [WIDTH-1:0]  partial remainder entering this step (< divisor)
//   dvd_bit               next dividend bit, MSB first
//   divisor  [WIDTH-1:0]  divisor (non-zero while iterating)
//   rem_out  [WIDTH-1:0]  partial remainder after trial subtract / restore
//   q_bit                 quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // The shifted remainder needs WIDTH+1 bits: rem_in < divisor, so the
    // shifted value is below 2*divisor and can exceed WIDTH bits.
    logic [WIDTH:0] shifted;

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path; the up-front defaults guarantee no latch is inferred.
        shifted = {rem_in, dvd_bit};
        rem_out = shifted[WIDTH-1:0];
        q_bit   = 1'b0;
        // Trial subtraction succeeds when the result would be non-negative;
        // otherwise the shifted value is kept unchanged (the restore).
        if (shifted >= {1'b0, divisor}) begin
            q_bit   = 1'b1;
            rem_out = WIDTH'(shifted - {1'b0, divisor});
        end
    end

endmodule

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Sequential restoring unsigned divider: one quotient bit per clock, MSB
// first, WIDTH iterations per division. Divide-by-zero completes at once.
// Ports:
//   clk                     system clock, rising edge
//   rst                     synchronous active-high reset
//   start                   request a division (ignored while busy)
//   a         [WIDTH-1:0]   dividend, captured on the accepting edge
//   b         [WIDTH-1:0]   divisor, captured on the accepting edge
//   quotient  [WIDTH-1:0]   quotient of the last completed operation
//   remainder [WIDTH-1:0]   remainder of the last completed operation
//   div_by_zero             last completed operation had a zero divisor
//   busy                    operation in progress
//   done                    one-cycle pulse when results become valid
// All outputs are registered. WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] rem_r;   // partial remainder
    logic [WIDTH-1:0] dvd_r;   // dividend bits shift out of the top while
                               // quotient bits shift in at the bottom
    logic [WIDTH-1:0] dvs_r;   // captured divisor

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .dvd_bit (dvd_r[WIDTH-1]),
        .divisor (dvs_r),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // NOTE: all state here is assigned with non-blocking (<=) so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rem_r       <= '0;
            dvd_r       <= '0;
            dvs_r       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start && (b == '0)) begin
                        // Zero divisor: report immediately, no iterations.
                        state       <= ST_DONE;
                        quotient    <= '1;
                        remainder   <= a;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                    end else if (start) begin
                        state <= ST_RUN;
                        dvd_r <= a;
                        dvs_r <= b;
                        rem_r <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                ST_RUN: begin
                    rem_r <= rem_next;
                    dvd_r <= {dvd_r[WIDTH-2:0], q_bit};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        // Final bit: publish results straight from the step
                        // so they appear together with the done pulse.
                        state       <= ST_DONE;
                        quotient    <= {dvd_r[WIDTH-2:0], q_bit};
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
